// File: rtl/mem_access.sv
// Memory-access pipeline stage: SRAM and memory-mapped UART accesses with an
// upstream stall while the access is in flight.
module mem_access (
    input  logic        emi_clk,
    input  logic        emi_rst,
    input  logic [15:0] mmi_instr,
    input  logic [15:0] mmi_pc,
    input  logic [15:0] mmi_data,
    input  logic [3:0]  mmi_wreg_addr,
    input  logic [15:0] mmi_mem_addr,
    input  logic [1:0]  mmi_rwe,
    output logic [15:0] mmo_instr,
    output logic [15:0] mmo_pc,
    output logic [15:0] mmo_data,
    output logic [3:0]  mmo_wreg_addr,
    output logic        mmo_stall,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_pop,
    input  logic        uart_tx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_push
);

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam logic [DW-1:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [DW-1:0] UART_STAT_ADDR = 16'hBF01;
    localparam logic [1:0]    RWE_RD = 2'b01;
    localparam logic [1:0]    RWE_WR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, UART, DONE} state_t;

    state_t        state, next_state;
    logic          op_wr;
    logic [DW-1:0] result;
    logic          req;
    logic          req_uart;
    logic          tx_wait;

    assign mmo_instr     = mmi_instr;
    assign mmo_pc        = mmi_pc;
    assign mmo_wreg_addr = mmi_wreg_addr;

    assign req      = (mmi_rwe == RWE_RD) || (mmi_rwe == RWE_WR);
    assign req_uart = (mmi_mem_addr == UART_DATA_ADDR) || (mmi_mem_addr == UART_STAT_ADDR);
    // A UART data write parks in UART until the transmitter can take the byte.
    assign tx_wait  = op_wr && (ram_addr == UART_DATA_ADDR) && !uart_tx_ready;

    always_ff @(posedge emi_clk or negedge emi_rst) begin
        if (!emi_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, stall and result forwarding.
    always_comb begin
        next_state = state;
        mmo_stall  = 1'b0;
        mmo_data   = mmi_data;
        case (state)
            IDLE: begin
                mmo_stall = req;
                if (req) begin
                    if (req_uart) begin
                        next_state = UART;
                    end else if (mmi_rwe == RWE_WR) begin
                        next_state = WR1;
                    end else begin
                        next_state = RD1;
                    end
                end
            end
            RD1: begin
                mmo_stall  = 1'b1;
                next_state = RD2;
            end
            RD2: begin
                mmo_stall  = 1'b1;
                next_state = DONE;
            end
            WR1: begin
                mmo_stall  = 1'b1;
                next_state = WR2;
            end
            WR2: begin
                mmo_stall  = 1'b1;
                next_state = DONE;
            end
            UART: begin
                mmo_stall = 1'b1;
                if (!tx_wait) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                mmo_data   = op_wr ? mmi_data : result;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (!emi_rst) begin
            mmo_stall = 1'b0;
        end
    end

    // SRAM strobes are flops fed from the next-state decode, so they never glitch.
    always_ff @(posedge emi_clk or negedge emi_rst) begin
        if (!emi_rst) begin
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
        end else begin
            ram_ce_n <= !((next_state == RD1) || (next_state == RD2) ||
                          (next_state == WR1) || (next_state == WR2));
            ram_oe_n <= !((next_state == RD1) || (next_state == RD2));
            ram_we_n <= !(next_state == WR1);
        end
    end

    // Address/data capture, read result and UART handshakes.
    always_ff @(posedge emi_clk or negedge emi_rst) begin
        if (!emi_rst) begin
            ram_addr     <= '0;
            ram_wdata    <= '0;
            op_wr        <= 1'b0;
            result       <= '0;
            uart_rx_pop  <= 1'b0;
            uart_tx_push <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            uart_rx_pop  <= 1'b0;
            uart_tx_push <= 1'b0;
            if ((state == IDLE) && req) begin
                ram_addr  <= mmi_mem_addr;
                ram_wdata <= mmi_data;
                op_wr     <= (mmi_rwe == RWE_WR);
            end
            if (state == RD2) begin
                result <= ram_rdata;
            end
            if ((state == UART) && !tx_wait) begin
                if (op_wr) begin
                    if (ram_addr == UART_DATA_ADDR) begin
                        uart_tx_push <= 1'b1;
                        uart_tx_data <= ram_wdata[BW-1:0];
                    end
                end else if (ram_addr == UART_DATA_ADDR) begin
                    if (uart_rx_valid) begin
                        result      <= DW'(uart_rx_data);
                        uart_rx_pop <= 1'b1;
                    end else begin
                        result <= '0;
                    end
                end else begin
                    result <= DW'({uart_rx_valid, uart_tx_ready});
                end
            end
        end
    end

endmodule
